uart_tx_frame_ctrl: RTL and testbench
=====================================

UART_TX_FRAME_CTRL -- requirements
Module: uart_tx_frame_ctrl

Interface
REQ-001 Parameter DATA_BITS, 8, payload bits per frame; legal range 5..8.
REQ-002 Parameter STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
REQ-003 tx_clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 tx_data  input  DATA_BITS  byte to transmit; sampled on accept.
REQ-006 tx_valid  input  1  requester has a byte on tx_data.
REQ-007 tx_ready  output  1  controller can accept a byte this cycle.
REQ-008 tx_tick  input  1  one-cycle bit-period pulse from the baud generator.
REQ-009 baud_gen_en  output  1  enable to the baud generator.
REQ-010 tx_line  output  1  serial line; idle high.
REQ-011 tx_busy  output  1  frame in progress.
REQ-012 tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-013 The block SHALL implement states IDLE, START, DATA, PARITY and STOP.
REQ-014 The block SHALL drive all outputs from registers.
REQ-015 IDLE SHALL drive tx_ready=1, tx_busy=0, baud_gen_en=0 and tx_line=1.
REQ-016 An accept SHALL occur when tx_valid=1 and tx_ready=1 on the same edge.
REQ-017 On accept the block SHALL latch tx_data into a shift register, enter START, and drive tx_line=0, baud_gen_en=1, tx_busy=1 and tx_ready=0 from the next cycle.
REQ-018 In every non-IDLE state, tx_ready SHALL be 0 and tx_valid SHALL be ignored; no queueing.
REQ-019 State and tx_line SHALL change only on edges where tx_tick=1, except on accept and on reset.
REQ-020 START + tick: enter DATA, tx_line = shift[0] (LSB first), bit counter = 0.
REQ-021 DATA + tick: shift right and increment the counter; after DATA_BITS ticks, enter PARITY (if compiled in) or STOP, with tx_line = parity bit or 1 respectively.
REQ-022 The bit counter SHALL be $clog2(DATA_BITS+1) bits wide and SHALL never exceed DATA_BITS.
REQ-023 STOP SHALL hold tx_line=1 for STOP_BITS ticks.
REQ-024 On the final STOP tick the block SHALL enter IDLE, pulse tx_done=1 for exactly one cycle, and drive baud_gen_en=0 and tx_ready=1 in that same cycle.
REQ-025 baud_gen_en SHALL drop only on that final tick, so the generator's counter rests at zero and the next frame's start bit is a full bit period.
REQ-026 Back-to-back: an accept in the tx_done cycle SHALL start the next frame the following cycle with no extra idle bit.
REQ-027 A tx_tick in IDLE SHALL be ignored.
REQ-028 Frame length SHALL be 1 + DATA_BITS + P + STOP_BITS ticks, where P = 1 with parity compiled in and 0 otherwise.

Reset
REQ-029 With rst=1 at an edge, the block SHALL enter IDLE with tx_line=1, tx_ready=1, tx_busy=0, tx_done=0, baud_gen_en=0, and the shift register and counter at 0.
REQ-030 Reset mid-frame SHALL abort the frame and return tx_line high on the next edge, with no tx_done pulse.
REQ-031 Reset SHALL take priority over an accept and over tx_tick on the same edge.

Configuration
REQ-032 Macro UART_TX_PARITY_EN defined: the PARITY state SHALL be compiled in and SHALL emit one even-parity bit (XOR of the latched payload) for one tick between DATA and STOP.
REQ-033 Macro UART_TX_PARITY_EN undefined: the PARITY state, its logic and the parity register SHALL be absent, and DATA SHALL go directly to STOP.

Verification
(All scenarios: DATA_BITS=8, STOP_BITS=1, bench drives tx_tick every 4th cycle while baud_gen_en=1.)
REQ-034 Reset during IDLE and during DATA -> tx_line=1, tx_ready=1, baud_gen_en=0 on the next edge, and no tx_done pulse.
REQ-035 Send 0xA5, parity compiled out -> tx_line sequence 0,1,0,1,0,0,1,0,1,1 per tick; one tx_done after 10 ticks.
REQ-036 Send 0x07 with UART_TX_PARITY_EN -> data bits 1,1,1,0,0,0,0,0 then parity 1 then stop 1; 11 ticks total.
REQ-037 Hold tx_valid high with 0x55 then 0xAA -> second accept occurs in the tx_done cycle; second start bit follows immediately; frames are contiguous.
REQ-038 Pulse tx_tick in IDLE and toggle tx_valid mid-frame -> no state change, no accept, tx_ready stays 0 until tx_done.
REQ-039 STOP_BITS=2, send 0xFF -> tx_line high for 2 ticks after the data bits; tx_done on the second stop tick.

Source files
------------

// File: rtl/uart_tx_frame_ctrl_if.sv
// uart_tx_frame_ctrl_if: requester handshake, baud-generator and serial-line signals of the UART framer.
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic tx_valid;
    logic tx_ready;
    logic tx_tick;
    logic baud_gen_en;
    logic tx_line;
    logic tx_busy;
    logic tx_done;
    modport master (
        output tx_data, tx_valid, tx_tick,
        input  tx_ready, baud_gen_en, tx_line, tx_busy, tx_done
    );
    modport slave (
        input  tx_data, tx_valid, tx_tick,
        output tx_ready, baud_gen_en, tx_line, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl: UART frame transmitter (start, DATA_BITS LSB-first, optional parity, STOP_BITS stops).
// Define UART_TX_PARITY_EN to compile in one even-parity bit between data and stop.
module uart_tx_frame_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input logic tx_clk,
    input logic rst,
    uart_tx_frame_ctrl_if.slave bus
);
    localparam int CW = $clog2(DATA_BITS + 1);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
    state_t state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [CW-1:0] cnt, cnt_n;
    logic stop_cnt, stop_cnt_n;
    logic line, line_n;
    logic ready, ready_n;
    logic busy, busy_n;
    logic done, done_n;
    logic en, en_n;
    logic last_data;
`ifdef UART_TX_PARITY_EN
    logic par, par_n;
`endif
    assign last_data = cnt == CW'(DATA_BITS - 1);
    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            cnt      <= '0;
            stop_cnt <= 1'b0;
            line     <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            en       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            cnt      <= cnt_n;
            stop_cnt <= stop_cnt_n;
            line     <= line_n;
            ready    <= ready_n;
            busy     <= busy_n;
            done     <= done_n;
            en       <= en_n;
`ifdef UART_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end
    // Every output is computed one cycle ahead so the ports come straight from flops.
    always_comb begin
        state_n    = state;
        shift_n    = shift;
        cnt_n      = cnt;
        stop_cnt_n = stop_cnt;
        line_n     = line;
        ready_n    = ready;
        busy_n     = busy;
        done_n     = 1'b0;
        en_n       = en;
`ifdef UART_TX_PARITY_EN
        par_n      = par;
`endif
        case (state)
            IDLE: if (bus.tx_valid && ready) begin
                state_n = START;
                shift_n = bus.tx_data;
                line_n  = 1'b0;
                en_n    = 1'b1;
                busy_n  = 1'b1;
                ready_n = 1'b0;
`ifdef UART_TX_PARITY_EN
                par_n   = ^bus.tx_data;
`endif
            end
            START: if (bus.tx_tick) begin
                state_n = DATA;
                line_n  = shift[0];
                cnt_n   = '0;
            end
            DATA: if (bus.tx_tick) begin
                shift_n = shift >> 1;
                cnt_n   = cnt + 1'b1;
                if (last_data) begin
`ifdef UART_TX_PARITY_EN
                    state_n = PARITY;
                    line_n  = par;
`else
                    state_n    = STOP;
                    line_n     = 1'b1;
                    stop_cnt_n = 1'b0;
`endif
                end else begin
                    line_n = shift[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bus.tx_tick) begin
                state_n    = STOP;
                line_n     = 1'b1;
                stop_cnt_n = 1'b0;
            end
`endif
            // Dropping the baud enable only here leaves the generator at zero for the next start bit.
            STOP: if (bus.tx_tick) begin
                if (stop_cnt == 1'(STOP_BITS - 1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    en_n    = 1'b0;
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    stop_cnt_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    assign bus.tx_line     = line;
    assign bus.tx_ready    = ready;
    assign bus.tx_busy     = busy;
    assign bus.tx_done     = done;
    assign bus.baud_gen_en = en;
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb_uart_tx_frame_ctrl: directed bench for the UART framer, one-stop and two-stop instances.
module tb_uart_tx_frame_ctrl;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
    localparam logic [15:0] F_A5 = 16'h054A;
    localparam logic [15:0] F_07 = 16'h060E;
    localparam logic [15:0] F_55 = 16'h04AA;
    localparam logic [15:0] F_AA = 16'h0554;
    localparam logic [15:0] F_FF2 = 16'h0DFE;
`else
    localparam int P = 0;
    localparam logic [15:0] F_A5 = 16'h034A;
    localparam logic [15:0] F_07 = 16'h020E;
    localparam logic [15:0] F_55 = 16'h02AA;
    localparam logic [15:0] F_AA = 16'h0354;
    localparam logic [15:0] F_FF2 = 16'h07FE;
`endif
    localparam int N1 = 10 + P;
    localparam int N2 = 11 + P;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic man_tick = 1'b0;
    logic sel = 1'b0;
    logic [1:0] bca, bcb;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    uart_tx_frame_ctrl_if #(.DATA_BITS(8)) a ();
    uart_tx_frame_ctrl_if #(.DATA_BITS(8)) b ();
    uart_tx_frame_ctrl #(.DATA_BITS(8), .STOP_BITS(1)) dut (.tx_clk(clk), .rst(rst), .bus(a));
    uart_tx_frame_ctrl #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (.tx_clk(clk), .rst(rst), .bus(b));
    always_ff @(posedge clk) bca <= a.baud_gen_en ? bca + 2'd1 : 2'd0;
    always_ff @(posedge clk) bcb <= b.baud_gen_en ? bcb + 2'd1 : 2'd0;
    assign a.tx_tick  = (a.baud_gen_en && bca == 2'd3) || man_tick;
    assign b.tx_tick  = (b.baud_gen_en && bcb == 2'd3) || man_tick;
    assign a.tx_valid = !sel && valid;
    assign b.tx_valid = sel && valid;
    assign a.tx_data  = data;
    assign b.tx_data  = data;
    wire cur_line  = sel ? b.tx_line : a.tx_line;
    wire cur_ready = sel ? b.tx_ready : a.tx_ready;
    wire cur_busy  = sel ? b.tx_busy : a.tx_busy;
    wire cur_done  = sel ? b.tx_done : a.tx_done;
    wire cur_en    = sel ? b.baud_gen_en : a.baud_gen_en;
    wire cur_tick  = sel ? b.tx_tick : a.tx_tick;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic idle_chk(input string tag);
        chk({tag, " line"}, cur_line, 1);
        chk({tag, " ready"}, cur_ready, 1);
        chk({tag, " busy"}, cur_busy, 0);
        chk({tag, " en"}, cur_en, 0);
        chk({tag, " done"}, cur_done, 0);
    endtask
    task automatic start_chk(input string tag);
        chk({tag, " start_line"}, cur_line, 0);
        chk({tag, " start_ready"}, cur_ready, 0);
        chk({tag, " start_busy"}, cur_busy, 1);
        chk({tag, " start_en"}, cur_en, 1);
        chk({tag, " start_done"}, cur_done, 0);
    endtask
    task automatic send(input string tag, input logic [7:0] d, input bit hold);
        @(negedge clk);
        data = d;
        valid = 1'b1;
        @(posedge clk);
        #1;
        start_chk(tag);
        if (!hold) valid = 1'b0;
    endtask
    task automatic next_tick(input string tag);
        int n = 0;
        @(negedge clk);
        while (!cur_tick && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!cur_tick) chk({tag, " tick_timeout"}, cur_tick, 1);
        @(posedge clk);
        #1;
    endtask
    task automatic run_frame(input string tag, input logic [15:0] frame, input int n);
        for (int i = 1; i <= n; i++) begin
            next_tick(tag);
            chk($sformatf("%s line@tick%0d", tag, i), cur_line, i < n ? frame[i] : 1'b1);
            chk($sformatf("%s done@tick%0d", tag, i), cur_done, i == n);
        end
        chk({tag, " end_ready"}, cur_ready, 1);
        chk({tag, " end_en"}, cur_en, 0);
        chk({tag, " end_busy"}, cur_busy, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1;
        idle_chk("reset");
        @(negedge clk);
        rst = 1'b0;
        // Reset while idle
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle_chk("rst_idle");
        @(negedge clk);
        rst = 1'b0;
        // 0xA5 full frame
        send("a5", 8'hA5, 1'b0);
        run_frame("a5", F_A5, N1);
        @(posedge clk);
        #1;
        idle_chk("a5_post");
        // Tick while idle is ignored
        @(negedge clk);
        man_tick = 1'b1;
        @(posedge clk);
        #1;
        man_tick = 1'b0;
        idle_chk("idle_tick");
        // 0x07 with valid toggling mid-frame
        send("x07", 8'h07, 1'b0);
        @(negedge clk);
        valid = 1'b1;
        data = 8'h00;
        @(posedge clk);
        #1;
        chk("x07 midframe_ready", cur_ready, 0);
        chk("x07 midframe_busy", cur_busy, 1);
        @(negedge clk);
        valid = 1'b0;
        run_frame("x07", F_07, N1);
        @(posedge clk);
        #1;
        idle_chk("x07_post");
        // Back-to-back 0x55 then 0xAA with valid held
        send("b2b55", 8'h55, 1'b1);
        data = 8'hAA;
        run_frame("b2b55", F_55, N1);
        @(posedge clk);
        #1;
        start_chk("b2baa");
        valid = 1'b0;
        run_frame("b2baa", F_AA, N1);
        // Reset during DATA aborts the frame
        send("rstdata", 8'hA5, 1'b0);
        next_tick("rstdata");
        chk("rstdata line1", cur_line, F_A5[1]);
        next_tick("rstdata");
        chk("rstdata line2", cur_line, F_A5[2]);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle_chk("rst_data");
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            seen += int'(cur_done) + int'(cur_busy);
        end
        chk("rst_data no_done_no_busy", seen, 0);
        // Reset wins over a simultaneous accept
        @(negedge clk);
        rst = 1'b1;
        valid = 1'b1;
        @(posedge clk);
        #1;
        idle_chk("rst_vs_accept");
        @(negedge clk);
        rst = 1'b0;
        valid = 1'b0;
        // Two stop bits on the second instance
        sel = 1'b1;
        @(posedge clk);
        #1;
        idle_chk("s2_idle");
        send("s2ff", 8'hFF, 1'b0);
        run_frame("s2ff", F_FF2, N2);
        @(posedge clk);
        #1;
        idle_chk("s2ff_post");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
